// File: rtl/memory_arbiter_pkg.sv
// Shared encodings and default sizes for the main-memory arbiter.
package memory_arbiter_pkg;

   localparam int DEF_MEMORY_ADDRESS_SIZE = 32;
   localparam int DEF_CACHE_LINE_SIZE     = 128;
   localparam int DEF_TIMEOUT_CYCLES      = 64;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_GRANT_IC = 2'd1,
      ARB_GRANT_DC = 2'd2,
      ARB_RELEASE  = 2'd3
   } arb_state_t;

   localparam logic OWNER_IC = 1'b0;
   localparam logic OWNER_DC = 1'b1;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Two-way round-robin picker: req[0]=ICache, req[1]=DCache; grant is one-hot or zero.
module memory_arbiter_rr_picker
   import memory_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = (last_owner == OWNER_DC) ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single main-memory port between ICache and DCache with round-robin
// tie-breaking and a watchdog that forces release of a grant whose memory never answers.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int MEMORY_ADDRESS_SIZE = DEF_MEMORY_ADDRESS_SIZE,
   parameter int CACHE_LINE_SIZE     = DEF_CACHE_LINE_SIZE,
   parameter int TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ic_op_init,
   input  logic                           ic_op_done,
   input  logic                           ic_start_access,
   input  logic [MEMORY_ADDRESS_SIZE-1:0] ic_address,
   output logic                           ic_allow_op,
   output logic                           ic_data_ready,
   input  logic                           dc_op_init,
   input  logic                           dc_op_done,
   input  logic                           dc_start_access,
   input  logic                           dc_op,
   input  logic [MEMORY_ADDRESS_SIZE-1:0] dc_address,
   input  logic [CACHE_LINE_SIZE-1:0]     dc_data_in,
   output logic                           dc_allow_op,
   output logic                           dc_data_ready,
   output logic [CACHE_LINE_SIZE-1:0]     line_out,
   output logic                           mem_enable,
   output logic                           mem_op,
   output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
   output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
   input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
   input  logic                           mem_data_ready,
   output logic                           timeout_err
);

   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

   arb_state_t state_q, state_d;
   logic       last_owner_q, last_owner_d;
   logic [7:0] wdog_q, wdog_d;
   logic [1:0] pick;
   logic       own_ic, own_dc, owner;
   logic       own_start, own_done, own_init, expire;

   memory_arbiter_rr_picker u_rr_picker (
      .req        ({dc_op_init, ic_op_init}),
      .last_owner (last_owner_q),
      .grant      (pick)
   );

   always_comb begin
      own_ic    = (state_q == ARB_GRANT_IC);
      own_dc    = (state_q == ARB_GRANT_DC);
      owner     = own_dc ? OWNER_DC : OWNER_IC;
      own_start = (own_ic & ic_start_access) | (own_dc & dc_start_access);
      own_done  = (own_ic & ic_op_done)      | (own_dc & dc_op_done);
      own_init  = (own_ic & ic_op_init)      | (own_dc & dc_op_init);
      expire    = (own_ic | own_dc) && (wdog_q == WDOG_LAST);
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      wdog_d       = wdog_q;
      case (state_q)
         ARB_IDLE: begin
            wdog_d = '0;
            if (pick[0]) begin
               state_d = ARB_GRANT_IC;
            end else if (pick[1]) begin
               state_d = ARB_GRANT_DC;
            end
         end
         ARB_GRANT_IC, ARB_GRANT_DC: begin
            if (mem_data_ready) begin
               wdog_d = '0;
            end else if (own_start) begin
               wdog_d = wdog_q + 8'd1;
            end
            // Owner is recorded on exit so the next IDLE tie goes to the other cache.
            if (own_done || !own_init || expire) begin
               state_d      = ARB_RELEASE;
               last_owner_d = owner;
            end
         end
         ARB_RELEASE: begin
            wdog_d  = '0;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ARB_IDLE;
         last_owner_q <= OWNER_DC;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         wdog_q       <= wdog_d;
      end
   end

   // Outputs decode the state register directly so an async reset drops them at once.
   always_comb begin
      ic_allow_op   = own_ic;
      dc_allow_op   = own_dc;
      ic_data_ready = own_ic & mem_data_ready;
      dc_data_ready = own_dc & mem_data_ready;
      line_out      = mem_data_out;
      mem_enable    = 1'b0;
      mem_op        = 1'b0;
      mem_address   = '0;
      mem_data_in   = '0;
      timeout_err   = expire;
      if (own_ic) begin
         mem_enable  = ic_start_access;
         mem_address = ic_address;
      end else if (own_dc) begin
         mem_enable  = dc_start_access;
         mem_op      = dc_op;
         mem_address = dc_address;
         mem_data_in = dc_data_in;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a scoreboard of expected data_ready deliveries.
module tb_memory_arbiter;

   localparam int MAS = 32;
   localparam int CLS = 128;
   localparam int TO  = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic           ic_op_init, ic_op_done, ic_start_access;
   logic [MAS-1:0] ic_address;
   logic           ic_allow_op, ic_data_ready;
   logic           dc_op_init, dc_op_done, dc_start_access, dc_op;
   logic [MAS-1:0] dc_address;
   logic [CLS-1:0] dc_data_in;
   logic           dc_allow_op, dc_data_ready;
   logic [CLS-1:0] line_out;
   logic           mem_enable, mem_op;
   logic [MAS-1:0] mem_address;
   logic [CLS-1:0] mem_data_in, mem_data_out;
   logic           mem_data_ready;
   logic           timeout_err;

   always #5 clk = ~clk;

   memory_arbiter #(
      .MEMORY_ADDRESS_SIZE (MAS),
      .CACHE_LINE_SIZE     (CLS),
      .TIMEOUT_CYCLES      (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ic_op_init      (ic_op_init),
      .ic_op_done      (ic_op_done),
      .ic_start_access (ic_start_access),
      .ic_address      (ic_address),
      .ic_allow_op     (ic_allow_op),
      .ic_data_ready   (ic_data_ready),
      .dc_op_init      (dc_op_init),
      .dc_op_done      (dc_op_done),
      .dc_start_access (dc_start_access),
      .dc_op           (dc_op),
      .dc_address      (dc_address),
      .dc_data_in      (dc_data_in),
      .dc_allow_op     (dc_allow_op),
      .dc_data_ready   (dc_data_ready),
      .line_out        (line_out),
      .mem_enable      (mem_enable),
      .mem_op          (mem_op),
      .mem_address     (mem_address),
      .mem_data_in     (mem_data_in),
      .mem_data_out    (mem_data_out),
      .mem_data_ready  (mem_data_ready),
      .timeout_err     (timeout_err)
   );

   typedef struct {
      logic           who;
      logic [CLS-1:0] line;
   } exp_t;

   exp_t           exp_q[$];
   exp_t           e;
   int             n_chk  = 0;
   int             n_pass = 0;
   logic [CLS-1:0] d;
   logic [CLS-1:0] aa_line;

   task automatic check(input string tag, input logic [CLS-1:0] obs, input logic [CLS-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic clr_inputs();
      ic_op_init = 0; ic_op_done = 0; ic_start_access = 0; ic_address = '0;
      dc_op_init = 0; dc_op_done = 0; dc_start_access = 0; dc_op = 0;
      dc_address = '0; dc_data_in = '0;
      mem_data_out = '0; mem_data_ready = 0;
   endtask

   task automatic do_reset();
      reset = 0;
      clr_inputs();
      repeat (2) cyc();
      reset = 1;
   endtask

   // Memory answers with a line; the owner is expected to see data_ready with it.
   task automatic mem_resp(input logic who, input logic [CLS-1:0] line);
      exp_t x;
      mem_data_ready = 1;
      mem_data_out   = line;
      x.who  = who;
      x.line = line;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      #3;
      if (ic_data_ready || dc_data_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_pending", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("sb_owner", dc_data_ready, e.who);
            check("sb_line", line_out, e.line);
            check("sb_exclusive", ic_data_ready & dc_data_ready, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      aa_line = {16{8'hAA}};
      reset = 0;
      clr_inputs();
      #1;
      check("rst_ic_allow", ic_allow_op, 0);
      check("rst_dc_allow", dc_allow_op, 0);
      check("rst_mem_enable", mem_enable, 0);
      check("rst_timeout", timeout_err, 0);
      cyc(); cyc();
      reset = 1;

      // 1: single IC request and read
      ic_op_init = 1; #1;
      check("t1_pre_grant", ic_allow_op, 0);
      cyc();
      ic_start_access = 1; ic_address = 'h100; #1;
      check("t1_ic_allow", ic_allow_op, 1);
      check("t1_dc_allow", dc_allow_op, 0);
      check("t1_mem_enable", mem_enable, 1);
      check("t1_mem_addr", mem_address, 'h100);
      check("t1_mem_op", mem_op, 0);
      check("t1_mem_din", mem_data_in, 0);
      repeat (4) begin cyc(); #1; check("t1_wait", ic_data_ready, 0); end
      cyc();
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_resp(1'b0, d); #1;
      check("t1_ic_ready", ic_data_ready, 1);
      check("t1_dc_ready", dc_data_ready, 0);
      check("t1_line", line_out, d);
      cyc();
      mem_data_ready = 0; ic_start_access = 0; #1;
      check("t1_ready_pulse", ic_data_ready, 0);
      ic_op_done = 1;
      cyc();
      ic_op_done = 0; ic_op_init = 0; #1;
      check("t1_release", ic_allow_op, 0);
      cyc();

      // 2: simultaneous requests alternate
      do_reset();
      ic_op_init = 1; dc_op_init = 1;
      cyc(); #1;
      check("t2_ic_first", ic_allow_op, 1);
      check("t2_dc_wait", dc_allow_op, 0);
      ic_op_done = 1;
      cyc();
      ic_op_done = 0; ic_op_init = 0; #1;
      check("t2_rel_ic", ic_allow_op, 0);
      check("t2_rel_dc", dc_allow_op, 0);
      cyc(); #1;
      check("t2_idle_dc", dc_allow_op, 0);
      cyc(); #1;
      check("t2_dc_grant", dc_allow_op, 1);
      dc_op_done = 1; ic_op_init = 1;
      cyc();
      dc_op_done = 0; #1;
      check("t2_rel2", dc_allow_op, 0);
      cyc(); cyc(); #1;
      check("t2_alt_ic", ic_allow_op, 1);
      check("t2_alt_dc", dc_allow_op, 0);
      ic_op_done = 1;
      cyc();
      ic_op_done = 0; ic_op_init = 0;
      cyc(); cyc(); #1;
      check("t2_dc_again", dc_allow_op, 1);

      // 3: DC write-back then fill under one grant
      dc_start_access = 1; dc_op = 1; dc_address = 'h2000; dc_data_in = aa_line; #1;
      check("t3_mem_enable", mem_enable, 1);
      check("t3_mem_op_wr", mem_op, 1);
      check("t3_mem_addr", mem_address, 'h2000);
      check("t3_mem_din", mem_data_in, aa_line);
      cyc(); cyc();
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_resp(1'b1, d); #1;
      check("t3_wb_ready", dc_data_ready, 1);
      check("t3_wb_ic_ready", ic_data_ready, 0);
      cyc();
      mem_data_ready = 0; dc_op = 0; #1;
      check("t3_keep_grant", dc_allow_op, 1);
      check("t3_mem_op_rd", mem_op, 0);
      cyc(); #1;
      check("t3_no_release", dc_allow_op, 1);
      cyc();
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_resp(1'b1, d); dc_op_done = 1; #1;
      check("t3_done_ready", dc_data_ready, 1);
      cyc();
      mem_data_ready = 0; dc_op_done = 0; dc_start_access = 0; dc_op_init = 0; #1;
      check("t3_release", dc_allow_op, 0);
      check("t3_mem_off", mem_enable, 0);
      cyc();

      // 4: watchdog forces release, pending IC then granted
      do_reset();
      dc_op_init = 1;
      cyc();
      dc_start_access = 1; ic_op_init = 1; #1;
      check("t4_dc_grant", dc_allow_op, 1);
      for (int k = 1; k <= TO; k++) begin
         if (k > 1) begin cyc(); #1; end
         check("t4_timeout", timeout_err, (k == TO));
      end
      check("t4_grant_at_expiry", dc_allow_op, 1);
      cyc();
      dc_start_access = 0; dc_op_init = 0; #1;
      check("t4_dropped", dc_allow_op, 0);
      check("t4_pulse_end", timeout_err, 0);
      cyc(); cyc(); #1;
      check("t4_ic_next", ic_allow_op, 1);

      // 5: async reset mid-access
      do_reset();
      dc_op_init = 1;
      cyc();
      dc_start_access = 1; dc_address = 'h3000; #1;
      check("t5_dc_grant", dc_allow_op, 1);
      check("t5_mem_enable", mem_enable, 1);
      #1 reset = 0;
      #1;
      check("t5_async_allow", dc_allow_op, 0);
      check("t5_async_mem", mem_enable, 0);
      cyc(); cyc();
      reset = 1; dc_start_access = 0; ic_op_init = 1;
      cyc(); #1;
      check("t5_tie_ic", ic_allow_op, 1);
      check("t5_tie_dc", dc_allow_op, 0);

      // 6: non-owner inputs ignored, owner abandonment releases
      ic_op_done = 1; ic_op_init = 0;
      cyc();
      ic_op_done = 0;
      cyc(); cyc(); #1;
      check("t6_dc_owner", dc_allow_op, 1);
      ic_op_init = 1; ic_op_done = 1; ic_start_access = 1; ic_address = 'h55; #1;
      check("t6_ic_no_mem", mem_enable, 0);
      check("t6_addr_dc", mem_address, 'h3000);
      cyc();
      ic_op_done = 0; #1;
      check("t6_ic_done_ignored", dc_allow_op, 1);
      ic_op_init = 0;
      cyc();
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_resp(1'b1, d); #1;
      check("t6_ic_init_drop", dc_allow_op, 1);
      check("t6_ic_gated", ic_data_ready, 0);
      cyc();
      mem_data_ready = 0; ic_start_access = 0; dc_op_init = 0; #1;
      check("t6_still_owner", dc_allow_op, 1);
      cyc(); #1;
      check("t6_abandon", dc_allow_op, 0);
      cyc(); #4;
      check("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
